alu_seq: RTL and testbench

- Registered, parametrised-width successor to the 16-bit combinational ALU.
- Keeps the CR16-style opcode values and the 5-bit flag layout {C,L,F,Z,N}.
- Adds a persistent processor status register (PSR) that feeds ADDC carry-in.
- Adds an iterative multi-cycle unsigned multiply and a valid/ready issue handshake.
- Sits between the register-file read stage and the writeback stage of the datapath.

---
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with persistent flag register (PSR) and an iterative
// shift-add multiplier behind a valid/ready issue handshake.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flags_clr,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [4:0]       psr,
  output logic             op_err
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_RSH  = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_CMPU = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_NOT  = 8'h20;
  localparam logic [7:0] OP_ARSH = 8'h82;
  localparam logic [7:0] OP_LSH  = 8'h84;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_result;
  logic [4:0]           r_psr;
  logic                 r_out_valid;
  logic                 r_op_err;
  logic [2*WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]     r_mb;
  logic [2*WIDTH-1:0]   r_acc;
  logic [SHW-1:0]       r_cnt;

  logic                 w_cin;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic                 w_big;
  logic [SHW-1:0]       w_sh;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c, w_l, w_f, w_n;
  logic                 w_cmp, w_upd, w_err, w_mul;
  logic [4:0]           w_flags;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign w_cin  = (opcode == OP_ADDC) ? r_psr[4] : 1'b0;
  assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff = {1'b0, a} - {1'b0, b};
  // WIDTH is a power of two, so any bit above the index field means amount >= WIDTH
  assign w_big  = |b[WIDTH-1:SHW];
  assign w_sh   = b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_l   = 1'b0;
    w_f   = 1'b0;
    w_n   = 1'b0;
    w_cmp = 1'b0;
    w_upd = 1'b1;
    w_err = 1'b0;
    w_mul = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_f   = (opcode != OP_ADDU) && (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_f   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP, OP_CMPU: begin
        w_cmp = 1'b1;
        w_l   = (a < b);
        w_n   = (opcode == OP_CMP) && ($signed(a) < $signed(b));
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOT:  w_res = ~a;
      OP_LSH:  w_res = w_big ? '0 : (a << w_sh);
      OP_RSH:  w_res = w_big ? '0 : (a >> w_sh);
      OP_ARSH: w_res = w_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> w_sh);
      OP_MUL:  w_mul = 1'b1;
      OP_NOP:  w_upd = 1'b0;
      default: begin
        w_upd = 1'b0;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_flags   = {w_c, w_l, w_f, (w_cmp ? (a == b) : (w_res == '0)), w_n};
  assign w_acc_nxt = r_acc + (r_mb[0] ? r_ma : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_psr       <= '0;
      r_out_valid <= 1'b0;
      r_op_err    <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_op_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_mul) begin
              r_state <= S_BUSY;
              r_ma    <= {{WIDTH{1'b0}}, a};
              r_mb    <= b;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else begin
              r_result    <= w_res;
              r_out_valid <= 1'b1;
              r_op_err    <= w_err;
              if (w_upd) r_psr <= w_flags;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_ma  <= r_ma << 1;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_result    <= w_acc_nxt[WIDTH-1:0];
            r_psr       <= {(|w_acc_nxt[2*WIDTH-1:WIDTH]), 2'b00,
                            (w_acc_nxt[WIDTH-1:0] == '0), 1'b0};
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // a clear request wins over any flag update landing on the same edge
      if (flags_clr) r_psr <= '0;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign psr       = r_psr;
  assign op_err    = r_op_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=16) with hand-computed expectations.
module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    opcode;
  logic [W-1:0]  a, b;
  logic          flags_clr;
  logic [W-1:0]  result;
  logic          out_valid;
  logic [4:0]    psr;
  logic          op_err;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .flags_clr(flags_clr), .result(result),
    .out_valid(out_valid), .psr(psr), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present one op for exactly one edge, then sample 1 time unit after it
  task automatic step(input logic [7:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  int lat;
  int busy;
  int pulses;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    opcode    = 8'h00;
    a         = '0;
    b         = '0;
    flags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_psr", psr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycle();

    step(8'h05, 16'h7FFF, 16'h0001);
    chk("add_ovf_result", result, 16'h8000);
    chk("add_ovf_psr", psr, 5'b00100);
    chk("add_ovf_valid", out_valid, 1);
    idle_cycle();
    chk("valid_one_cycle", out_valid, 0);

    step(8'h05, 16'hFFFF, 16'h0001);
    chk("add_carry_result", result, 16'h0000);
    chk("add_carry_psr", psr, 5'b10010);
    step(8'h07, 16'h0001, 16'h0001);
    chk("addc_result", result, 16'h0003);
    chk("addc_psr", psr, 5'b00000);
    chk("addc_b2b_valid", out_valid, 1);

    step(8'h0B, 16'hFFFF, 16'h0001);
    chk("cmp_result", result, 0);
    chk("cmp_psr", psr, 5'b00001);
    step(8'h0D, 16'hFFFF, 16'h0001);
    chk("cmpu_psr", psr, 5'b00000);
    step(8'h0B, 16'h1234, 16'h1234);
    chk("cmp_eq_psr", psr, 5'b00010);

    step(8'h09, 16'h0001, 16'h0002);
    chk("sub_borrow_result", result, 16'hFFFF);
    chk("sub_borrow_psr", psr, 5'b10000);
    step(8'h09, 16'h8000, 16'h0001);
    chk("sub_ovf_result", result, 16'h7FFF);
    chk("sub_ovf_psr", psr, 5'b00100);

    step(8'h01, 16'hF0F0, 16'h0F0F);
    chk("and_result", result, 16'h0000);
    chk("and_psr", psr, 5'b00010);
    step(8'h03, 16'hF0F0, 16'h0FF0);
    chk("xor_result", result, 16'hFF00);
    step(8'h20, 16'h00FF, 16'h0000);
    chk("not_result", result, 16'hFF00);
    chk("not_psr", psr, 5'b00000);

    step(8'h82, 16'h8000, 16'd20);
    chk("arsh_big", result, 16'hFFFF);
    step(8'h0A, 16'h8000, 16'd20);
    chk("rsh_big", result, 16'h0000);
    chk("rsh_big_psr", psr, 5'b00010);
    step(8'h84, 16'h0001, 16'd15);
    chk("lsh_15", result, 16'h8000);
    step(8'h84, 16'h1234, 16'd0);
    chk("lsh_0", result, 16'h1234);
    step(8'h82, 16'h8000, 16'd4);
    chk("arsh_4", result, 16'hF800);

    step(8'h0E, 16'h0100, 16'h0100);
    opcode = 8'h05;
    a      = 16'hFFFF;
    b      = 16'hFFFF;
    chk("mul_ready_low", in_ready, 0);
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      idle_cycle();
      lat++;
    end
    chk("mul_latency", lat, 17);
    chk("mul_busy_cycles", busy, 16);
    chk("mul_ovf_result", result, 16'h0000);
    chk("mul_ovf_psr", psr, 5'b10010);
    chk("mul_ready_back", in_ready, 1);

    step(8'h0E, 16'h0003, 16'h0005);
    lat = 1;
    while (!out_valid && lat < 40) begin
      idle_cycle();
      lat++;
    end
    chk("mul35_latency", lat, 17);
    chk("mul35_result", result, 16'h000F);
    chk("mul35_psr", psr, 5'b00000);

    step(8'h05, 16'hFFFF, 16'h0001);
    chk("pre_rst_psr", psr, 5'b10010);
    step(8'h0E, 16'h0002, 16'h0002);
    repeat (7) idle_cycle();
    chk("mul_still_busy", in_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("busy_rst_psr", psr, 0);
    chk("busy_rst_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      idle_cycle();
      if (out_valid) pulses++;
    end
    chk("busy_rst_no_valid", pulses, 0);
    chk("busy_rst_result", result, 0);

    step(8'h05, 16'hFFFF, 16'h0001);
    step(8'hFF, 16'h1111, 16'h2222);
    chk("bad_op_err", op_err, 1);
    chk("bad_op_valid", out_valid, 1);
    chk("bad_op_result", result, 0);
    chk("bad_op_psr_held", psr, 5'b10010);
    idle_cycle();
    chk("bad_op_err_pulse", op_err, 0);
    step(8'h00, 16'h5555, 16'h5555);
    chk("nop_valid", out_valid, 1);
    chk("nop_psr_held", psr, 5'b10010);

    flags_clr = 1'b1;
    step(8'h05, 16'h7FFF, 16'h0001);
    flags_clr = 1'b0;
    chk("clr_result", result, 16'h8000);
    chk("clr_psr", psr, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
